// File: rtl/wb_arb_pkg.sv
// Shared types and arbitration rule for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam int NB_MASTERS = 2;

  // req[n] is master n's cyc; on a tie the master that did not own the bus last wins.
  function automatic arb_state_t next_grant(input logic [NB_MASTERS-1:0] req, input logic last);
    arb_state_t grant;
    grant = IDLE;
    case (req)
      2'b01:   grant = GNT0;
      2'b10:   grant = GNT1;
      2'b11:   grant = last ? GNT0 : GNT1;
      default: grant = IDLE;
    endcase
    return grant;
  endfunction

endpackage

// File: rtl/wshb_if.sv
// Wishbone classic/registered-feedback bus bundle, 32-bit data with byte selects.
interface wshb_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADR_WIDTH  = 32
) (
  input logic clk
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [ADR_WIDTH-1:0]    adr;
  logic [DATA_WIDTH-1:0]   dat_ms;
  logic [DATA_WIDTH-1:0]   dat_sm;
  logic [DATA_WIDTH/8-1:0] sel;
  logic [2:0]              cti;
  logic [1:0]              bte;
  logic                    ack;
  logic                    err;
  logic                    rty;

  modport master (
    input  clk,
    output cyc, stb, we, adr, dat_ms, sel, cti, bte,
    input  ack, err, rty, dat_sm
  );

  modport slave (
    input  clk,
    input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
    output ack, err, rty, dat_sm
  );
endinterface

// File: rtl/wb_arb_timeout.sv
// Watchdog for the arbiter: counts stalled cycles of the current owner and flags expiry.
module wb_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count_reg;

  // Saturates at the limit so expiry stays stable until the clear arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en && count_reg != LIMIT) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == LIMIT);
endmodule

// File: rtl/wb_arbiter.sv
// Two-master round-robin Wishbone arbiter onto one slave port.
// Optional owner watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic    clk,
  input logic    rst,
  wshb_if.slave  wb_s0,
  wshb_if.slave  wb_s1,
  wshb_if.master wb_m
);
  arb_state_t state_reg, state_next;
  logic       last_reg, last_next;
  logic       own0, own1;
  logic       expired;

  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("wb_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: state_next = next_grant({wb_s1.cyc, wb_s0.cyc}, last_reg);
      GNT0: begin
        if (expired) begin
          state_next = IDLE;
          last_next  = 1'b0;
        end else if (!wb_s0.cyc) begin
          state_next = next_grant({wb_s1.cyc, 1'b0}, last_reg);
          last_next  = 1'b0;
        end
      end
      GNT1: begin
        if (expired) begin
          state_next = IDLE;
          last_next  = 1'b1;
        end else if (!wb_s1.cyc) begin
          state_next = next_grant({1'b0, wb_s0.cyc}, last_reg);
          last_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign own0 = (state_reg == GNT0);
  assign own1 = (state_reg == GNT1);

  always_comb begin
    wb_m.cyc    = 1'b0;
    wb_m.stb    = 1'b0;
    wb_m.we     = 1'b0;
    wb_m.adr    = '0;
    wb_m.dat_ms = '0;
    wb_m.sel    = '0;
    wb_m.cti    = '0;
    wb_m.bte    = '0;
    if (own0) begin
      wb_m.cyc    = wb_s0.cyc;
      wb_m.stb    = wb_s0.stb;
      wb_m.we     = wb_s0.we;
      wb_m.adr    = wb_s0.adr;
      wb_m.dat_ms = wb_s0.dat_ms;
      wb_m.sel    = wb_s0.sel;
      wb_m.cti    = wb_s0.cti;
      wb_m.bte    = wb_s0.bte;
    end else if (own1) begin
      wb_m.cyc    = wb_s1.cyc;
      wb_m.stb    = wb_s1.stb;
      wb_m.we     = wb_s1.we;
      wb_m.adr    = wb_s1.adr;
      wb_m.dat_ms = wb_s1.dat_ms;
      wb_m.sel    = wb_s1.sel;
      wb_m.cti    = wb_s1.cti;
      wb_m.bte    = wb_s1.bte;
    end
    // A timed-out cycle is cut off from the slave while err goes back to the owner.
    if (expired) begin
      wb_m.cyc = 1'b0;
      wb_m.stb = 1'b0;
    end
  end

  assign wb_s0.ack    = own0 & wb_m.ack;
  assign wb_s0.err    = own0 & (wb_m.err | expired);
  assign wb_s0.rty    = own0 & wb_m.rty;
  assign wb_s0.dat_sm = own0 ? wb_m.dat_sm : '0;
  assign wb_s1.ack    = own1 & wb_m.ack;
  assign wb_s1.err    = own1 & (wb_m.err | expired);
  assign wb_s1.rty    = own1 & wb_m.rty;
  assign wb_s1.dat_sm = own1 ? wb_m.dat_sm : '0;

`ifdef WB_ARB_TIMEOUT_EN
  logic owner_stb;
  assign owner_stb = (own0 & wb_s0.stb) | (own1 & wb_s1.stb);

  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .en     (owner_stb & ~wb_m.ack),
    .clr    (wb_m.ack | (state_next != state_reg)),
    .expired(expired)
  );
`else
  assign expired = 1'b0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: arbitration table, hand sequences, randomized model check.
module tb_wb_arbiter;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 256;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stub = 1'b0;
  always #5 clk = ~clk;

  wshb_if wb0 (.clk(clk));
  wshb_if wb1 (.clk(clk));
  wshb_if wbm (.clk(clk));

  wb_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk  (clk),
    .rst  (rst),
    .wb_s0(wb0),
    .wb_s1(wb1),
    .wb_m (wbm)
  );

  // Slave model: single-cycle acknowledge, or never when stubbed.
  logic [31:0] mem [0:255];
  assign wbm.ack    = wbm.cyc & wbm.stb & ~stub;
  assign wbm.err    = 1'b0;
  assign wbm.rty    = 1'b0;
  assign wbm.dat_sm = mem[wbm.adr[9:2]];
  always @(posedge clk) begin
    if (wbm.ack && wbm.we) begin
      for (int b = 0; b < 4; b++)
        if (wbm.sel[b]) mem[wbm.adr[9:2]][8*b +: 8] <= wbm.dat_ms[8*b +: 8];
    end
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Owner seen on the slave port; master 1 always uses addresses with bit 8 set.
  function automatic int owner_obs();
    if (!wbm.cyc) return 2;
    return wbm.adr[8] ? 1 : 0;
  endfunction

  task automatic drive(input int m, input bit cyc, input bit stb, input bit we,
                       input logic [31:0] adr, input logic [31:0] dat);
    if (m == 0) begin
      wb0.cyc = cyc; wb0.stb = stb; wb0.we = we; wb0.adr = adr;
      wb0.dat_ms = dat; wb0.sel = 4'hF; wb0.cti = 3'd0; wb0.bte = 2'd0;
    end else begin
      wb1.cyc = cyc; wb1.stb = stb; wb1.we = we; wb1.adr = adr | 32'h100;
      wb1.dat_ms = dat; wb1.sel = 4'hF; wb1.cti = 3'd0; wb1.bte = 2'd0;
    end
  endtask

  typedef struct {
    bit c0;
    bit c1;
    int owner;
  } vec_t;

  vec_t tbl [15];
  int   exp_prev, cnt0, cnt1, err_at, err_cnt, err1_cnt, own_m, last_m, got;
  bit   c0, c1, s0, s1;

  initial begin
    tbl[0]  = '{0, 0, 2};  tbl[1]  = '{1, 1, 0};  tbl[2]  = '{1, 1, 0};
    tbl[3]  = '{0, 1, 1};  tbl[4]  = '{0, 1, 1};  tbl[5]  = '{1, 1, 1};
    tbl[6]  = '{1, 0, 0};  tbl[7]  = '{0, 0, 2};  tbl[8]  = '{1, 1, 1};
    tbl[9]  = '{0, 0, 2};  tbl[10] = '{1, 1, 0};  tbl[11] = '{0, 0, 2};
    tbl[12] = '{0, 1, 1};  tbl[13] = '{1, 0, 0};  tbl[14] = '{0, 0, 2};
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);

    // Reset state
    #3;
    check("rst_cyc", {31'd0, wbm.cyc}, 0);
    check("rst_ack0", {31'd0, wb0.ack}, 0);
    check("rst_ack1", {31'd0, wb1.ack}, 0);
    check("rst_err0", {31'd0, wb0.err}, 0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;

    // Arbitration table
    for (int i = 0; i < 15; i++) begin
      drive(0, tbl[i].c0, tbl[i].c0, 0, 32'h20, 0);
      drive(1, tbl[i].c1, tbl[i].c1, 0, 32'h40, 0);
      tick();
      check($sformatf("tbl%0d_owner", i), owner_obs(), tbl[i].owner);
      check($sformatf("tbl%0d_ack0", i), {31'd0, wb0.ack}, (tbl[i].owner == 0) ? 1 : 0);
      check($sformatf("tbl%0d_ack1", i), {31'd0, wb1.ack}, (tbl[i].owner == 1) ? 1 : 0);
    end

    // Master 0 writes then reads back under one cycle
    drive(0, 1, 1, 1, 32'h10, 32'hDEADBEEF);
    #2;
    check("wr_pre_grant_cyc", {31'd0, wbm.cyc}, 0);
    tick();
    check("wr_grant_stb", {31'd0, wbm.stb}, 1);
    check("wr_ack0", {31'd0, wb0.ack}, 1);
    check("wr_ack1", {31'd0, wb1.ack}, 0);
    tick();
    drive(0, 1, 1, 0, 32'h10, 0);
    #1;
    check("rd_data0", wb0.dat_sm, 32'hDEADBEEF);
    check("rd_ack0", {31'd0, wb0.ack}, 1);
    check("rd_ack1", {31'd0, wb1.ack}, 0);
    check("rd_dat1", wb1.dat_sm, 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // Master 1 burst of 8 reads while master 0 waits
    cnt0 = 0; cnt1 = 0;
    for (int b = 0; b < 8; b++) begin
      drive(1, 1, 1, 0, 32'h4 * b, 0);
      tick();
      if (b == 0) drive(0, 1, 1, 0, 32'h20, 0);
      cnt0 += int'(wb0.ack);
      cnt1 += int'(wb1.ack);
    end
    check("burst_ack1_count", cnt1, 8);
    check("burst_ack0_count", cnt0, 0);
    drive(1, 0, 0, 0, 0, 0);
    tick();
    check("burst_handover_owner", owner_obs(), 0);
    check("burst_handover_ack0", {31'd0, wb0.ack}, 1);
    drive(0, 0, 0, 0, 0, 0);
    tick();

    // Asynchronous reset in the middle of a master 0 read
    drive(0, 1, 1, 0, 32'h30, 0);
    tick();
    check("pre_rst_owner", owner_obs(), 0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_cyc", {31'd0, wbm.cyc}, 0);
    check("async_rst_stb", {31'd0, wbm.stb}, 0);
    check("async_rst_ack0", {31'd0, wb0.ack}, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    drive(0, 1, 1, 0, 32'h30, 0);
    drive(1, 1, 1, 0, 32'h30, 0);
    tick();
    check("post_rst_tie_owner", owner_obs(), 0);

    // Continuous single-beat requests alternate
    exp_prev = 0;
    for (int i = 1; i <= 10; i++) begin
      drive(0, exp_prev != 0, exp_prev != 0, 0, 32'h30, 0);
      drive(1, exp_prev != 1, exp_prev != 1, 0, 32'h30, 0);
      tick();
      check($sformatf("alt%0d_owner", i), owner_obs(), i % 2);
      exp_prev = i % 2;
    end
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    tick();

    // Slave that never acknowledges
    stub = 1'b1;
    drive(0, 1, 1, 0, 32'h50, 0);
    tick();
    check("stall_owner", owner_obs(), 0);
    drive(1, 1, 1, 0, 32'h50, 0);
    err_at = -1; err_cnt = 0; err1_cnt = 0;
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) tick();
      err1_cnt += int'(wb1.err);
      if (wb0.err) begin
        err_cnt++;
        if (err_at < 0) err_at = c;
        drive(0, 0, 0, 0, 0, 0);
      end
    end
    check("stall_err1_count", err1_cnt, 0);
`ifdef WB_ARB_TIMEOUT_EN
    check("timeout_err_cycle", err_at, 4);
    check("timeout_err_count", err_cnt, 1);
    got = 0;
    for (int c = 0; c < 4 && got == 0; c++) begin
      if (owner_obs() == 1) got = 1;
      else tick();
    end
    check("timeout_next_grant", got, 1);
`else
    check("no_timeout_err_count", err_cnt, 0);
    check("no_timeout_owner_held", owner_obs(), 0);
    drive(0, 0, 0, 0, 0, 0);
    tick();
    check("stall_release_owner", owner_obs(), 1);
`endif
    stub = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    tick();

    // Randomized traffic against a behavioural ownership model
    #2; rst = 1'b1; #2; rst = 1'b0;
    own_m = 2; last_m = 1; c0 = 0; c1 = 0;
    for (int n = 0; n < 400; n++) begin
      c0 = c0 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      c1 = c1 ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      s0 = c0 && ($urandom_range(0, 4) != 0);
      s1 = c1 && ($urandom_range(0, 4) != 0);
      drive(0, c0, s0, 1'($urandom_range(0, 1)), $urandom_range(0, 255) & 32'hFC, $urandom);
      drive(1, c1, s1, 1'($urandom_range(0, 1)), $urandom_range(0, 255) & 32'hFC, $urandom);
      if (own_m == 2) begin
        if (c0 && c1) own_m = 1 - last_m;
        else if (c0) own_m = 0;
        else if (c1) own_m = 1;
      end else if (!((own_m == 0) ? c0 : c1)) begin
        last_m = own_m;
        if (own_m == 0) own_m = c1 ? 1 : 2;
        else            own_m = c0 ? 0 : 2;
      end
      tick();
      check($sformatf("rnd%0d_owner", n), owner_obs(), own_m);
      check($sformatf("rnd%0d_ack0", n), {31'd0, wb0.ack}, (own_m == 0 && s0) ? 1 : 0);
      check($sformatf("rnd%0d_ack1", n), {31'd0, wb1.ack}, (own_m == 1 && s1) ? 1 : 0);
      check($sformatf("rnd%0d_dat0", n), wb0.dat_sm, (own_m == 0) ? mem[wb0.adr[9:2]] : 32'h0);
      check($sformatf("rnd%0d_dat1", n), wb1.dat_sm, (own_m == 1) ? mem[wb1.adr[9:2]] : 32'h0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Two-master Wishbone arbiter sharing one slave port, typically the `wb_bram` framebuffer memory, between a writer (pattern generator or host) and a reader (video controller). It grants the slave to one master per bus cycle (`cyc` held), alternates round-robin on contention, and routes the slave's `ack`, `err` and `rty` and its read data back to the owner only. It sits between the masters' `wshb_if` instances and the slave's `wshb_if`, all in the single system clock domain.

## Interface
- `TIMEOUT_CYCLES`, default 256: watchdog limit in cycles without `ack` while granted. Used only when `WB_ARB_TIMEOUT_EN` is defined. Must be ≥ 2.
- `clk`  in  1: system clock. Same clock as that carried by all three interfaces.
- `rst`  in  1: reset, asynchronous, active-high.
- `wb_s0`  `wshb_if.slave`  (32-bit data, 4-bit `sel`): master 0. Wins the first arbitration after reset.
- `wb_s1`  `wshb_if.slave`  (32-bit data, 4-bit `sel`): master 1.
- `wb_m`  `wshb_if.master`  (32-bit data, 4-bit `sel`): shared slave port.

## Operation
- The FSM in `wb_arb_pkg::arb_state_t` has three states: `IDLE`, `GNT0`, `GNT1`. There is one `last` register, 0 or 1, holding the most recent owner.
- `IDLE`:
  - If only `wb_s0.cyc` is high, go to `GNT0`. If only `wb_s1.cyc` is high, go to `GNT1`.
  - If both are high, grant the master not equal to `last`.
- `GNTn`:
  - Stay while `wb_sn.cyc` is high.
  - When it drops, go to `GNT(1-n)` if that master's `cyc` is high, otherwise go to `IDLE`.
  - Set `last` to n on leaving the state.
- Mux, combinational from the registered state:
  - `wb_m.{adr,dat_ms,sel,we,cti,bte,stb,cyc}` come from the owner.
  - In `IDLE`, `cyc`, `stb` and `we` are 0 and the other fields are 0.
- Return path:
  - The owner receives `wb_m.ack/err/rty/dat_sm`.
  - The non-owner sees `ack=err=rty=0` and `dat_sm=0`, so its `stb` stalls until granted.
- An owner holding `cyc` keeps the grant across multiple `stb` phases, including bursts and read-modify-write. There is no preemption except by the timeout.
- Reset:
  - State goes to `IDLE` and `last` to 1.
  - All `wb_m` outputs read 0 immediately, because reset is asynchronous.
  - All master-side `ack/err/rty` outputs read 0.
  - A transfer in flight at reset is abandoned with no response.

## Timing
- Arbitration latency is one cycle. A `cyc` rising at edge k in `IDLE` gives the grant at edge k+1, and `wb_m.stb` is visible to the slave in cycle k+1.
- Handover without a bubble: the owner drops `cyc` at edge k and the other master is driven on `wb_m` from edge k+1.
- Added response latency is zero, since the `ack` path is combinational. A classic `wb_bram` read gives `ack` 2 cycles after grant and a write gives `ack` in the grant cycle.
- Simultaneous requests from `IDLE` are resolved by `last`. A request arriving in the same cycle as the owner's release is granted at the next edge.

## Configuration
- `WB_ARB_TIMEOUT_EN` defined:
  - A counter runs while the owner has `stb` high and `wb_m.ack` is low. It clears on `ack`, on state change and on reset.
  - When the count reaches `TIMEOUT_CYCLES`, the arbiter asserts the owner's `err` for one cycle, forces `wb_m.cyc/stb` to 0 in that cycle, and goes to `IDLE`, setting `last` to n.
  - The owner must drop `cyc` on `err`. If it keeps `cyc` high, it re-arbitrates normally.
- `WB_ARB_TIMEOUT_EN` undefined:
  - No counter is built, and `err` is passed through from `wb_m` only.
  - The grant is held indefinitely while `cyc` stays high.

## Structure
- Package `wb_arb_pkg` holds:
  - `arb_state_t`, a 2-bit enum: `IDLE=0`, `GNT0=1`, `GNT1=2`.
  - Constant `NB_MASTERS=2`.
  - The function `next_grant(req, last)`.
- Sub-module `wb_arb_timeout` is the watchdog: `clk`, `rst`, `en`, `clr`, and a `expired` output. It has a `$clog2(TIMEOUT_CYCLES+1)`-bit saturating counter and is instantiated only under `WB_ARB_TIMEOUT_EN`.

## Test plan
- Master 0 alone writes `0xDEADBEEF` to `adr=0x10`, `sel=4'hF`, then reads it back. Required: read data `0xDEADBEEF`, `wb_s1` sees no `ack`, grant latency is 1 cycle.
- Both masters raise `cyc` at the same edge after reset. Required: master 0 is granted first. Master 1 is granted at the edge after master 0 drops `cyc`, with no `IDLE` cycle between the two grants.
- Master 1 performs 8 back-to-back reads under one `cyc` while master 0 requests. Required: all 8 `ack`s go to master 1, and master 0 is granted only after master 1 releases.
- Both masters request continuously with single-beat cycles. Required: grants strictly alternate 0,1,0,1 over 10 cycles.
- `rst` pulses asynchronously mid-read while `GNT0`. Required: `wb_m.cyc`/`stb` are 0 before the next clock edge, the FSM is in `IDLE`, and after release master 0 still wins a tie.
- With `WB_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES=4`, and a stub slave that never asserts `ack`: required a one-cycle `err` to the owner 4 cycles after `stb`, followed by grant to the waiting master. Without the macro, no `err` is generated.
